pulse_train_gen: RTL and testbench
==================================

# pulse_train_gen

Counterpart of the pulse-to-tick detector (PTD), which reduces a level pulse to a single-cycle tick. This block expands a single-cycle trigger back into a timed level waveform: on one trigger it emits a programmable train of `count` pulses, each `high_len` cycles high, separated by `low_len` cycles low. In SafeBox it drives timed outputs such as the lock solenoid strobe and the buzzer beep pattern from one-cycle events produced by the keypad/FSM logic.

## Interface
- `LEN_W`, default 16: width of the high/low length fields, in clock cycles.
- `CNT_W`, default 4: width of the pulse-count field.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `trig`  in  1  single-cycle start request; sampled only in IDLE.
- `high_len`  in  LEN_W  high time per pulse, in cycles; latched on accepted `trig`.
- `low_len`  in  LEN_W  gap between pulses, in cycles; latched on accepted `trig`.
- `count`  in  CNT_W  number of pulses; latched on accepted `trig`.
- `abort`  in  1  synchronous cancel; takes effect on the next edge.
- `pulse_out`  out  1  generated waveform, registered.
- `busy`  out  1  high from the first high cycle through the last high cycle of the train.
- `done`  out  1  one-cycle tick after a train completes normally.

## Operation
- States: IDLE, HIGH, LOW, FIN.
- **IDLE:**
  - A `trig` with `count != 0` latches all three fields and moves to HIGH.
  - `trig` with `count == 0` is ignored: no pulse, no `done`.
- **Length clamping:** `high_len == 0` or `low_len == 0` is treated as 1.
- **HIGH:**
  - `pulse_out` = 1, `busy` = 1.
  - The length counter runs down from the latched `high_len`.
  - On expiry, the remaining-pulse counter decrements.
  - If pulses remain, go to LOW; otherwise go to FIN.
- **LOW:**
  - `pulse_out` = 0, `busy` = 1.
  - The counter runs down from `low_len`, then returns to HIGH.
- **FIN:** `done` = 1, `busy` = 0, `pulse_out` = 0 for exactly one cycle, then IDLE.
- **Busy-time triggers:** `trig` outside IDLE is dropped. There is no queueing and no retrigger extension.
- **`abort`:**
  - In any state, the next state is IDLE with `pulse_out` = 0 and `busy` = 0.
  - No `done` is generated.
  - `abort` and `trig` in the same IDLE cycle: `abort` wins and the train does not start.
- **Input stability:** input field changes during a train have no effect; only the values latched at the accepted `trig` are used.
- **Counter arithmetic:**
  - Counters are unsigned, LEN_W and CNT_W wide, and count down.
  - An expiry test on value 1 gives exact lengths.
  - Maximum high_len or low_len is 2^LEN_W−1 and does not wrap.

## Timing
- **Reset values:** `pulse_out` = 0, `busy` = 0, `done` = 0, state IDLE, counters 0.
- **Reset mid-train:** outputs drop low asynchronously; the train is not resumed.
- **Start latency:** with `trig` sampled at edge k, `pulse_out` is high on cycles k+1 … k+H. Here H, L and N are the clamped high length, clamped low length and pulse count.
- **Pulse period:** each pulse starts H+L cycles after the previous one starts.
- **Busy window:** `busy` is high for exactly N·H + (N−1)·L cycles, starting at k+1. There is no trailing low gap after the last pulse.
- **Completion:** `done` is high on cycle k+1+N·H+(N−1)·L.
- **Back-to-back trains:** the earliest next accepted `trig` is the cycle after `done`, i.e. on return to IDLE.
- **Outputs:** all outputs come directly from registers, with no combinational path from inputs.

## Structure
- **Shared package** `safebox_pkg`:
  - state enum `ptg_state_t` (IDLE, HIGH, LOW, FIN);
  - default width constants `PTG_LEN_W` = 16 and `PTG_CNT_W` = 4.
- **Sub-module** `load_down_counter` (parameter WIDTH; ports `load`, `load_val`, `en`, `expire`), instantiated twice: once for length, once for pulses remaining.
- The top level holds the FSM, the latched fields and the output registers.

## Test plan
- **Basic train:** H=3, L=2, N=3, trig at edge 10.
  - `pulse_out` high on cycles 11–13, 16–18 and 21–23.
  - `busy` high on cycles 11–23; `done` only on cycle 24.
- **Zero / clamp:**
  - N=0 trig gives no activity at all.
  - H=0, L=0, N=2 gives the pattern 1,0,1, then `done` on the next cycle.
- **Trig while busy:** H=4, L=4, N=2; re-trig during the second pulse. Waveform and `done` time are unchanged and no second train follows.
- **Abort:** H=5, L=5, N=4; `abort` during the second LOW.
  - Next cycle: `pulse_out` = 0, `busy` = 0, and `done` never asserts.
  - A trig 2 cycles later starts a fresh train.
- **Reset mid-train:** `rst_n` goes low during HIGH. Outputs go to 0 immediately; after release, IDLE, and only a new trig starts a train.
- **Limits / back-to-back:**
  - H=16'hFFFF, N=1 gives exactly 65535 high cycles.
  - A trig on the cycle after `done` is accepted, and a trig coinciding with `done` is dropped.

Source files
------------

// File: rtl/safebox_pkg.sv
// Shared SafeBox types and widths.
// Pulse-train generator states and default field widths.
package safebox_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    FIN  = 2'd3
  } ptg_state_t;

  localparam int PTG_LEN_W = 16;
  localparam int PTG_CNT_W = 4;

endpackage

// File: rtl/pulse_train_gen_if.sv
// Trigger/field/waveform bundle for pulse_train_gen.
// Master drives the request fields; slave returns the waveform.
interface pulse_train_gen_if
  import safebox_pkg::*;
#(
  parameter int LEN_W = PTG_LEN_W,
  parameter int CNT_W = PTG_CNT_W
) ();

  logic             trig;
  logic [LEN_W-1:0] high_len;
  logic [LEN_W-1:0] low_len;
  logic [CNT_W-1:0] count;
  logic             abort;
  logic             pulse_out;
  logic             busy;
  logic             done;

  modport master (
    output trig,
    output high_len,
    output low_len,
    output count,
    output abort,
    input  pulse_out,
    input  busy,
    input  done
  );

  modport slave (
    input  trig,
    input  high_len,
    input  low_len,
    input  count,
    input  abort,
    output pulse_out,
    output busy,
    output done
  );

endinterface

// File: rtl/load_down_counter.sv
// Loadable down counter; expire flags the last cycle of a run.
// Stops at zero so an idle counter never wraps.
module load_down_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             expire
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign expire = (cnt == WIDTH'(1));

endmodule

// File: rtl/pulse_train_gen.sv
// Expands a one-cycle trigger into a train of timed pulses.
// FSM, latched lengths and registered outputs live here.
module pulse_train_gen
  import safebox_pkg::*;
#(
  parameter int LEN_W = PTG_LEN_W,
  parameter int CNT_W = PTG_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  pulse_train_gen_if.slave   bus
);

  ptg_state_t state, next;

  logic [LEN_W-1:0] high_q;
  logic [LEN_W-1:0] low_q;
  logic [LEN_W-1:0] high_cl;
  logic [LEN_W-1:0] low_cl;
  logic [LEN_W-1:0] len_val;

  logic len_load, len_en, len_exp;
  logic pls_load, pls_en, pls_exp;
  logic accept;

  logic pulse_q, busy_q, done_q;

  // Zero lengths behave as one cycle
  assign high_cl = (bus.high_len == '0) ? LEN_W'(1) : bus.high_len;
  assign low_cl  = (bus.low_len  == '0) ? LEN_W'(1) : bus.low_len;

  assign accept = (state == IDLE) && bus.trig &&
                  (bus.count != '0) && !bus.abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_q <= '0;
      low_q  <= '0;
    end else if (accept) begin
      high_q <= high_cl;
      low_q  <= low_cl;
    end
  end

  always_comb begin
    next     = state;
    len_load = 1'b0;
    len_val  = high_q;
    len_en   = 1'b0;
    pls_load = 1'b0;
    pls_en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          next     = HIGH;
          len_load = 1'b1;
          len_val  = high_cl;
          pls_load = 1'b1;
        end
      end
      HIGH: begin
        len_en = 1'b1;
        if (len_exp) begin
          if (pls_exp) begin
            next = FIN;
          end else begin
            next     = LOW;
            len_load = 1'b1;
            len_val  = low_q;
            pls_en   = 1'b1;
          end
        end
      end
      LOW: begin
        len_en = 1'b1;
        if (len_exp) begin
          next     = HIGH;
          len_load = 1'b1;
          len_val  = high_q;
        end
      end
      FIN: next = IDLE;
      default: next = IDLE;
    endcase
    // Cancel overrides everything, including a same-cycle start
    if (bus.abort) begin
      next     = IDLE;
      len_load = 1'b0;
      len_en   = 1'b0;
      pls_load = 1'b0;
      pls_en   = 1'b0;
    end
  end

  load_down_counter #(.WIDTH(LEN_W)) u_len_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (len_load),
    .load_val (len_val),
    .en       (len_en),
    .expire   (len_exp)
  );

  load_down_counter #(.WIDTH(CNT_W)) u_pls_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pls_load),
    .load_val (bus.count),
    .en       (pls_en),
    .expire   (pls_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (1'b1)
        (next == HIGH): begin
          pulse_q <= 1'b1;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
        end
        (next == LOW): begin
          pulse_q <= 1'b0;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
        end
        (next == FIN): begin
          pulse_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: begin
          pulse_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pulse_out = pulse_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench for pulse_train_gen.
// Expected {pulse,busy,done} per cycle is queued when a trig is accepted.
module tb_pulse_train_gen;

  logic clk;
  logic rst_n;

  pulse_train_gen_if bus ();

  pulse_train_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] sb_q[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_train(input logic [15:0] h,
                            input logic [15:0] l,
                            input logic [3:0]  n);
    int hc;
    int lc;
    hc = (h == 16'd0) ? 1 : int'(h);
    lc = (l == 16'd0) ? 1 : int'(l);
    for (int p = 0; p < int'(n); p++) begin
      for (int i = 0; i < hc; i++) sb_q.push_back(3'b110);
      if (p < int'(n) - 1)
        for (int i = 0; i < lc; i++) sb_q.push_back(3'b010);
    end
    sb_q.push_back(3'b001);
  endtask

  // Check the current cycle, then drive inputs for the next edge
  task automatic tick(input logic        t,
                      input logic [15:0] h,
                      input logic [15:0] l,
                      input logic [3:0]  n,
                      input logic        a);
    logic [2:0] exp;
    logic       idle;
    @(negedge clk);
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 3'b000;
    chk("out", {29'd0, bus.pulse_out, bus.busy, bus.done}, {29'd0, exp});
    idle = (exp == 3'b000);
    bus.trig     = t;
    bus.high_len = h;
    bus.low_len  = l;
    bus.count    = n;
    bus.abort    = a;
    if (a) sb_q.delete();
    else if (idle && t && n != 4'd0) push_train(h, l, n);
  endtask

  task automatic idle_n(input int k);
    for (int i = 0; i < k; i++) tick(1'b0, 16'd7, 16'd9, 4'd5, 1'b0);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.trig     = 1'b0;
    bus.high_len = '0;
    bus.low_len  = '0;
    bus.count    = '0;
    bus.abort    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", {29'd0, bus.pulse_out, bus.busy, bus.done}, 32'd0);
    rst_n = 1'b1;
    idle_n(3);

    // Basic train, field changes during it must not matter
    tick(1'b1, 16'd3, 16'd2, 4'd3, 1'b0);
    idle_n(20);

    // Zero count, then zero lengths clamp to one
    tick(1'b1, 16'd5, 16'd5, 4'd0, 1'b0);
    idle_n(5);
    tick(1'b1, 16'd0, 16'd0, 4'd2, 1'b0);
    idle_n(6);

    // Retrigger during the second pulse is dropped
    tick(1'b1, 16'd4, 16'd4, 4'd2, 1'b0);
    idle_n(8);
    tick(1'b1, 16'd4, 16'd4, 4'd2, 1'b0);
    idle_n(10);

    // Abort in the second LOW, fresh train two cycles later
    tick(1'b1, 16'd5, 16'd5, 4'd4, 1'b0);
    idle_n(16);
    tick(1'b0, 16'd5, 16'd5, 4'd4, 1'b1);
    idle_n(1);
    tick(1'b1, 16'd2, 16'd1, 4'd2, 1'b0);
    idle_n(10);

    // Abort and trig together in IDLE
    tick(1'b1, 16'd3, 16'd3, 4'd1, 1'b1);
    idle_n(5);

    // Async reset during HIGH
    tick(1'b1, 16'd6, 16'd2, 4'd2, 1'b0);
    idle_n(3);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", {29'd0, bus.pulse_out, bus.busy, bus.done}, 32'd0);
    sb_q.delete();
    idle_n(2);
    rst_n = 1'b1;
    idle_n(5);
    tick(1'b1, 16'd2, 16'd2, 4'd1, 1'b0);
    idle_n(5);

    // Trig with done dropped, trig the cycle after accepted
    tick(1'b1, 16'd2, 16'd1, 4'd1, 1'b0);
    idle_n(2);
    tick(1'b1, 16'd2, 16'd1, 4'd1, 1'b0);
    tick(1'b1, 16'd1, 16'd1, 4'd2, 1'b0);
    idle_n(6);

    // Maximum high length
    tick(1'b1, 16'hFFFF, 16'd3, 4'd1, 1'b0);
    idle_n(65540);

    chk("sb_drain", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
